mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if -- control/operand/result bundle of the multiply/divide unit.
//
//   move     2   control request: 00 none, 01 mfhi, 10 mflo, 11 mult/div
//   funct    6   instruction funct: 011000 mult, 011010 div
//   rsData  32   operand A (multiplicand / dividend)
//   rtData  32   operand B (multiplier / divisor)
//   stall    1   hold PC and the current instruction
//   busy     1   iteration in progress
//   hiLoOut 32   mfhi/mflo read data for write-back
//
// master: pipeline/control side.  slave: the unit itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface mul_div_unit_if;
  logic [1:0]  move;
  logic [5:0]  funct;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        stall;
  logic        busy;
  logic [31:0] hiLoOut;

  modport master (output move, funct, rsData, rtData,
                  input  stall, busy, hiLoOut);
  modport slave  (input  move, funct, rsData, rtData,
                  output stall, busy, hiLoOut);
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit -- iterative signed 32x32 multiply / 32/32 divide with HI:LO.
//
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    mul_div_unit_if.slave (move, funct, rsData, rtData -> stall,
//          busy, hiLoOut)
//
// Operation: a start latches operand magnitudes and signs, BUSY runs 32
// one-bit iterations (shift-add or restoring shift-subtract), DONE applies
// sign correction and writes HI/LO. Fixed 34-cycle latency.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mul_div_unit (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] hi, lo;
  logic [31:0] acc_hi, acc_lo;   // mult: product {hi,lo}; div: {remainder, quotient}
  logic [31:0] op_a, op_b;       // operand magnitudes
  logic        op_div, sign_a, sign_b;
  logic        start;

  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  assign start = (bus.move == 2'b11) &&
                 ((bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV));

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: the default assignment at the top keeps this block from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (count == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;   // move==11 here is the same instruction; ignored
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.stall = 1'b0;
    bus.busy  = 1'b0;
    if (reset) begin
      bus.stall = ((state == IDLE) && start) || (state == BUSY);
      bus.busy  = (state == BUSY);
    end
  end

  // ---------------- one iteration step ----------------
  logic [32:0] mult_sum;
  logic [32:0] div_shift;
  logic [31:0] div_trial;
  logic        div_fits;

  always_comb begin
    mult_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    // Wrap-around low word is exact whenever the subtraction fits.
    div_trial = div_shift[31:0] - op_b;
    div_fits  = div_shift[32] || (div_shift[31:0] >= op_b);
  end

  // ---------------- sign correction ----------------
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, dividend;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    quot_fix = (sign_a ^ sign_b) ? (32'd0 - acc_lo) : acc_lo;
    rem_fix  = sign_a ? (32'd0 - acc_hi) : acc_hi;   // remainder follows dividend
    dividend = sign_a ? (32'd0 - op_a) : op_a;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_div <= (bus.funct == FUNCT_DIV);
          sign_a <= bus.rsData[31];
          sign_b <= bus.rtData[31];
          op_a   <= magnitude(bus.rsData);
          op_b   <= magnitude(bus.rtData);
          acc_hi <= '0;
          // Multiplier shifts out of acc_lo; dividend shifts out of acc_lo.
          acc_lo <= (bus.funct == FUNCT_DIV) ? magnitude(bus.rsData)
                                              : magnitude(bus.rtData);
          count  <= '0;
        end
        BUSY: begin
          count <= count + 5'd1;
          if (op_div) begin
            acc_hi <= div_fits ? div_trial : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_fits};
          end else begin
            acc_hi <= mult_sum[32:1];
            acc_lo <= {mult_sum[0], acc_lo[31:1]};
          end
        end
        DONE: begin
          if (!op_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (op_b == 32'd0) begin
            hi <= dividend;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- read port ----------------
  always_comb begin
    bus.hiLoOut = '0;
    if (reset) begin
      case (bus.move)
        2'b01:   bus.hiLoOut = hi;
        2'b10:   bus.hiLoOut = lo;
        default: bus.hiLoOut = '0;
      endcase
    end
  end

endmodule
